usb_reg_frontend: RTL and testbench
===================================

// Module: usb_reg_frontend
// PURPOSE
//  Initiator side of the register bus used by all register blocks (trace, clock, etc.).
//  Converts the CW305 SAM3U external-memory bus into the register interface:
//  reg_address/reg_bytecnt/reg_read/reg_write/reg_addrvalid/write_data, and returns read_data to USB.
//  Slaves decode reg_address[7:6] themselves; read_data from slaves is OR-combined at top level.
// PARAMETERS
//  pADDR_WIDTH    21  USB address bus width
//  pBYTECNT_SIZE  7   low address bits used as byte count; reg_address = upper pADDR_WIDTH-pBYTECNT_SIZE bits
// PORTS
//  usb_clk        in   1                          sole clock
//  reset_n        in   1                          asynchronous, active-low reset
//  usb_addr       in   pADDR_WIDTH                USB address bus
//  usb_alen       in   1                          address latch enable, active low
//  usb_cen        in   1                          chip enable, active low
//  usb_rdn        in   1                          read strobe, active low
//  usb_wrn        in   1                          write strobe, active low
//  usb_din        in   8                          data from USB (write)
//  usb_dout       out  8                          data to USB (read)
//  usb_isout      out  1                          high = FPGA drives data pins
//  reg_address    out  pADDR_WIDTH-pBYTECNT_SIZE  register address
//  reg_bytecnt    out  pBYTECNT_SIZE              byte index within register
//  reg_addrvalid  out  1                          address valid
//  write_data     out  8                          write byte
//  reg_write      out  1                          one-cycle write strobe
//  reg_read       out  1                          one-cycle read strobe
//  read_data      in   8                          slave data, valid exactly 1 cycle after reg_read
//  O_proto_err    out  1                          sticky: rdn and wrn low together; cleared only by reset
// BEHAVIOUR
//  - Reset: all outputs 0; sync flops preset to 1 (strobes inactive); FSM = IDLE.
//  - alen/cen/rdn/wrn pass 2-flop synchronisers; edges detected on synced versions. Addr/data buses
//    are sampled on the detected edge (bus timing guarantees stability).
//  - Address: synced alen low with cen low -> latch reg_address = addr[MSBs], base bytecnt = addr[LSBs],
//    burst offset = 0. reg_addrvalid is 1 from the next cycle until synced cen goes high.
//  - reg_bytecnt = base + offset, mod 2^pBYTECNT_SIZE (wraps silently; 127 -> 0 at default).
//  - FSM: IDLE -> ADDR (cen low) -> {WR_PULSE | RD_REQ -> RD_CAP -> RD_HOLD} -> ADDR; cen high -> IDLE.
//  - Write: wrn falling edge in ADDR -> write_data <= usb_din, go WR_PULSE; reg_write = 1 for that cycle
//    only; offset++ on exit. Pin wrn fall to reg_write high = 3 usb_clk cycles.
//  - Read: rdn falling edge in ADDR -> RD_REQ: reg_read = 1 for one cycle, usb_isout = 1.
//    RD_CAP: usb_dout <= read_data. RD_HOLD: usb_dout held, usb_isout = 1 until synced rdn rises,
//    then usb_isout = 0, offset++, back to ADDR. usb_dout retains its last value otherwise.
//  - rdn and wrn both low in ADDR: no strobe issued, O_proto_err <= 1, stay in ADDR.
//  - New alen in ADDR: relatch address, offset = 0, no strobes.
//  - cen high mid-operation: an already-issued single-cycle strobe completes; no further strobes;
//    usb_isout and reg_addrvalid drop the next cycle; FSM -> IDLE; offset not incremented.
//  - Async reset mid-operation: all outputs 0 immediately, no strobes issued after release until a
//    new address phase.
//  - reg_read and reg_write are never high together; at most one strobe per USB access.
// STRUCTURE
//  - Shared package/defines: FSM state encodings, SYNC_STAGES = 2, USB strobe polarity constants.
//  - One sub-module: usb_strobe_sync (parameterised multi-bit 2-flop sync, reset-to-1, async reset_n),
//    instantiated once for {alen, cen, rdn, wrn}.
// TESTING
//  1 Write addr 0x0C80 (reg_address=0x19, bytecnt=0), din=0xA5 -> one reg_write, write_data=0xA5,
//    bytecnt 0, 3 cycles after wrn fall.
//  2 Burst of 8 writes after one alen at bytecnt=0 -> reg_bytecnt 0..7 on successive reg_write pulses.
//  3 Read with stub slave returning 0x41 one cycle after reg_read -> usb_dout=0x41, usb_isout high
//    until rdn rises, exactly one reg_read.
//  4 Base bytecnt=126, 3 writes -> bytecnt 126, 127, 0 (wrap).
//  5 rdn and wrn low together -> no strobes, O_proto_err=1; stays 1 after later good accesses.
//  6 cen high during RD_HOLD, then reset_n pulse mid-write -> isout/addrvalid drop next cycle;
//    all outputs 0 on reset, no strobes after release.

Source files
------------

// File: rtl/usb_reg_frontend_pkg.sv
// usb_reg_frontend_pkg: shared constants for the USB register-bus front end
package usb_reg_frontend_pkg;
  localparam int SYNC_STAGES = 2;
  localparam logic STROBE_ACTIVE = 1'b0;
  localparam logic STROBE_IDLE = 1'b1;
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_ADDR     = 3'd1;
  localparam logic [2:0] ST_WR_PULSE = 3'd2;
  localparam logic [2:0] ST_RD_REQ   = 3'd3;
  localparam logic [2:0] ST_RD_CAP   = 3'd4;
  localparam logic [2:0] ST_RD_HOLD  = 3'd5;
endpackage

// File: rtl/usb_reg_frontend_if.sv
// usb_reg_frontend_if: register bus between the USB front end and register slaves
interface usb_reg_frontend_if #(
  parameter int pADDR_WIDTH   = 21,
  parameter int pBYTECNT_SIZE = 7
);
  logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0] reg_address;
  logic [pBYTECNT_SIZE-1:0]             reg_bytecnt;
  logic                                 reg_addrvalid;
  logic [7:0]                           write_data;
  logic                                 reg_write;
  logic                                 reg_read;
  logic [7:0]                           read_data;
  modport master (
    output reg_address, reg_bytecnt, reg_addrvalid, write_data, reg_write, reg_read,
    input  read_data
  );
  modport slave (
    input  reg_address, reg_bytecnt, reg_addrvalid, write_data, reg_write, reg_read,
    output read_data
  );
endinterface

// File: rtl/usb_strobe_sync.sv
// usb_strobe_sync: multi-bit synchroniser for active-low strobes, presets to inactive
module usb_strobe_sync
  import usb_reg_frontend_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int STAGES = SYNC_STAGES
) (
  input  logic             usb_clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [STAGES*WIDTH-1:0] sr;
  always_ff @(posedge usb_clk or negedge reset_n)
    if (!reset_n) sr <= '1;
    else sr <= {sr[(STAGES-1)*WIDTH-1:0], d};
  assign q = sr[STAGES*WIDTH-1 -: WIDTH];
endmodule

// File: rtl/usb_reg_frontend.sv
// usb_reg_frontend: SAM3U external-memory bus to register-bus initiator
module usb_reg_frontend
  import usb_reg_frontend_pkg::*;
#(
  parameter int pADDR_WIDTH   = 21,
  parameter int pBYTECNT_SIZE = 7
) (
  input  logic                   usb_clk,
  input  logic                   reset_n,
  input  logic [pADDR_WIDTH-1:0] usb_addr,
  input  logic                   usb_alen,
  input  logic                   usb_cen,
  input  logic                   usb_rdn,
  input  logic                   usb_wrn,
  input  logic [7:0]             usb_din,
  output logic [7:0]             usb_dout,
  output logic                   usb_isout,
  output logic                   O_proto_err,
  usb_reg_frontend_if.master     reg_bus
);
  localparam int AW = pADDR_WIDTH - pBYTECNT_SIZE;
  logic alen_s, cen_s, rdn_s, wrn_s, rdn_q, wrn_q;
  logic [2:0] state, nxt;
  logic [AW-1:0] addr;
  logic [pBYTECNT_SIZE-1:0] base, ofs;
  logic valid, inc;
  logic [7:0] wdata;
  usb_strobe_sync #(.WIDTH(4)) u_sync (
    .usb_clk (usb_clk),
    .reset_n (reset_n),
    .d       ({usb_alen, usb_cen, usb_rdn, usb_wrn}),
    .q       ({alen_s, cen_s, rdn_s, wrn_s})
  );
  wire cen_hi   = cen_s == STROBE_IDLE;
  wire latch    = alen_s == STROBE_ACTIVE && !cen_hi && (state == ST_IDLE || state == ST_ADDR);
  wire both_low = rdn_s == STROBE_ACTIVE && wrn_s == STROBE_ACTIVE;
  wire wr_fall  = wrn_q == STROBE_IDLE && wrn_s == STROBE_ACTIVE;
  wire rd_fall  = rdn_q == STROBE_IDLE && rdn_s == STROBE_ACTIVE;
  wire rdn_hi   = rdn_s == STROBE_IDLE;
  // cen high always wins: any strobe already issued still completes, nothing new starts
  always_comb begin
    nxt = state;
    inc = 1'b0;
    case (state)
      ST_IDLE:     nxt = latch ? ST_ADDR : ST_IDLE;
      ST_ADDR:     nxt = cen_hi ? ST_IDLE : (latch || both_low) ? ST_ADDR :
                         wr_fall ? ST_WR_PULSE : rd_fall ? ST_RD_REQ : ST_ADDR;
      ST_WR_PULSE: begin
        nxt = cen_hi ? ST_IDLE : ST_ADDR;
        inc = !cen_hi;
      end
      ST_RD_REQ:   nxt = cen_hi ? ST_IDLE : ST_RD_CAP;
      ST_RD_CAP:   nxt = cen_hi ? ST_IDLE : ST_RD_HOLD;
      ST_RD_HOLD:  begin
        nxt = cen_hi ? ST_IDLE : rdn_hi ? ST_ADDR : ST_RD_HOLD;
        inc = !cen_hi && rdn_hi;
      end
      default:     nxt = ST_IDLE;
    endcase
  end
  always_ff @(posedge usb_clk or negedge reset_n)
    if (!reset_n) begin
      state       <= ST_IDLE;
      rdn_q       <= STROBE_IDLE;
      wrn_q       <= STROBE_IDLE;
      addr        <= '0;
      base        <= '0;
      ofs         <= '0;
      valid       <= 1'b0;
      wdata       <= '0;
      usb_dout    <= '0;
      O_proto_err <= 1'b0;
    end else begin
      state <= nxt;
      rdn_q <= rdn_s;
      wrn_q <= wrn_s;
      if (latch) begin
        addr <= usb_addr[pADDR_WIDTH-1:pBYTECNT_SIZE];
        base <= usb_addr[pBYTECNT_SIZE-1:0];
        ofs  <= '0;
      end else if (inc) ofs <= ofs + pBYTECNT_SIZE'(1);
      valid <= cen_hi ? 1'b0 : latch ? 1'b1 : valid;
      if (nxt == ST_WR_PULSE && state == ST_ADDR) wdata <= usb_din;
      if (state == ST_RD_CAP) usb_dout <= reg_bus.read_data;
      if (state == ST_ADDR && !cen_hi && both_low) O_proto_err <= 1'b1;
    end
  assign usb_isout             = state == ST_RD_REQ || state == ST_RD_CAP || state == ST_RD_HOLD;
  assign reg_bus.reg_address   = addr;
  assign reg_bus.reg_bytecnt   = base + ofs;
  assign reg_bus.reg_addrvalid = valid;
  assign reg_bus.write_data    = wdata;
  assign reg_bus.reg_write     = state == ST_WR_PULSE;
  assign reg_bus.reg_read      = state == ST_RD_REQ;
endmodule

// File: tb/tb_usb_reg_frontend.sv
// tb_usb_reg_frontend: directed scoreboard bench for usb_reg_frontend
module tb_usb_reg_frontend;
  typedef struct packed {
    logic [13:0] a;
    logic [6:0]  c;
    logic [7:0]  d;
  } wexp_t;
  typedef struct packed {
    logic [13:0] a;
    logic [6:0]  c;
  } rexp_t;
  logic usb_clk = 1'b0, reset_n = 1'b0;
  logic [20:0] usb_addr = '0;
  logic usb_alen = 1'b1, usb_cen = 1'b1, usb_rdn = 1'b1, usb_wrn = 1'b1;
  logic [7:0] usb_din = '0, usb_dout, slave_val = '0;
  logic usb_isout, o_err;
  int compared = 0, mismatched = 0, wr_cnt = 0, rd_cnt = 0;
  wexp_t wq[$];
  rexp_t rq[$];
  wexp_t we;
  rexp_t re;
  always #5 usb_clk = ~usb_clk;
  usb_reg_frontend_if #(.pADDR_WIDTH(21), .pBYTECNT_SIZE(7)) bus ();
  usb_reg_frontend dut (
    .usb_clk     (usb_clk),
    .reset_n     (reset_n),
    .usb_addr    (usb_addr),
    .usb_alen    (usb_alen),
    .usb_cen     (usb_cen),
    .usb_rdn     (usb_rdn),
    .usb_wrn     (usb_wrn),
    .usb_din     (usb_din),
    .usb_dout    (usb_dout),
    .usb_isout   (usb_isout),
    .O_proto_err (o_err),
    .reg_bus     (bus)
  );
  always @(posedge usb_clk) bus.read_data <= bus.reg_read ? slave_val : 8'h00;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  always @(negedge usb_clk) begin
    if (bus.reg_write) begin
      wr_cnt++;
      if (wq.size() == 0) chk("wr_queue_depth", 32'(wq.size()), 1);
      else begin
        we = wq.pop_front();
        chk("wr_addr", 32'(bus.reg_address), 32'(we.a));
        chk("wr_bytecnt", 32'(bus.reg_bytecnt), 32'(we.c));
        chk("wr_data", 32'(bus.write_data), 32'(we.d));
        chk("wr_no_read", 32'(bus.reg_read), 0);
      end
    end
    if (bus.reg_read) begin
      rd_cnt++;
      if (rq.size() == 0) chk("rd_queue_depth", 32'(rq.size()), 1);
      else begin
        re = rq.pop_front();
        chk("rd_addr", 32'(bus.reg_address), 32'(re.a));
        chk("rd_bytecnt", 32'(bus.reg_bytecnt), 32'(re.c));
        chk("rd_isout", 32'(usb_isout), 1);
      end
    end
  end
  task automatic tick(input int n);
    repeat (n) @(posedge usb_clk);
    #1;
  endtask
  task automatic addr_phase(input logic [20:0] a);
    usb_addr = a;
    usb_cen  = 1'b0;
    usb_alen = 1'b0;
    tick(3);
    usb_alen = 1'b1;
    tick(3);
  endtask
  task automatic wr(input logic [7:0] d, input logic [13:0] a, input logic [6:0] c);
    int lat = 0;
    wq.push_back('{a, c, d});
    usb_din = d;
    usb_wrn = 1'b0;
    do begin
      tick(1);
      lat++;
    end while (!bus.reg_write && lat < 20);
    chk("wr_latency", lat, 3);
    usb_wrn = 1'b1;
    tick(4);
  endtask
  task automatic rd(input logic [7:0] v, input logic [13:0] a, input logic [6:0] c);
    int lat = 0;
    slave_val = v;
    rq.push_back('{a, c});
    usb_rdn = 1'b0;
    do begin
      tick(1);
      lat++;
    end while (!usb_isout && lat < 20);
    chk("rd_latency", lat, 3);
    tick(5);
    chk("rd_dout", 32'(usb_dout), 32'(v));
    chk("rd_isout_hold", 32'(usb_isout), 1);
  endtask
  initial begin
    tick(3);
    chk("rst_addr", 32'(bus.reg_address), 0);
    chk("rst_bytecnt", 32'(bus.reg_bytecnt), 0);
    chk("rst_valid", 32'(bus.reg_addrvalid), 0);
    chk("rst_strobes", 32'({bus.reg_write, bus.reg_read}), 0);
    chk("rst_out", 32'({usb_dout, usb_isout, o_err}), 0);
    reset_n = 1'b1;
    tick(2);
    addr_phase(21'h000C80);
    chk("t1_valid", 32'(bus.reg_addrvalid), 1);
    chk("t1_addr", 32'(bus.reg_address), 'h19);
    wr(8'hA5, 14'h19, 7'd0);
    addr_phase(21'h000C80);
    for (int i = 0; i < 8; i++) wr(8'(8'h10 + i), 14'h19, 7'(i));
    addr_phase(21'h001000);
    rd(8'h41, 14'h20, 7'd0);
    usb_rdn = 1'b1;
    tick(3);
    chk("t3_isout_drop", 32'(usb_isout), 0);
    chk("t3_dout_keep", 32'(usb_dout), 'h41);
    chk("t3_rd_count", rd_cnt, 1);
    addr_phase(21'h0002FE);
    wr(8'h01, 14'h05, 7'd126);
    wr(8'h02, 14'h05, 7'd127);
    wr(8'h03, 14'h05, 7'd0);
    addr_phase(21'h000C80);
    chk("t5_err_before", 32'(o_err), 0);
    usb_rdn = 1'b0;
    usb_wrn = 1'b0;
    tick(6);
    chk("t5_err_set", 32'(o_err), 1);
    chk("t5_no_wr", wr_cnt, 12);
    chk("t5_no_rd", rd_cnt, 1);
    usb_rdn = 1'b1;
    usb_wrn = 1'b1;
    tick(4);
    wr(8'h3C, 14'h19, 7'd0);
    chk("t5_err_sticky", 32'(o_err), 1);
    addr_phase(21'h001085);
    rd(8'h77, 14'h21, 7'd5);
    usb_cen = 1'b1;
    tick(2);
    chk("t6_isout_before", 32'(usb_isout), 1);
    tick(1);
    chk("t6_isout_drop", 32'(usb_isout), 0);
    chk("t6_valid_drop", 32'(bus.reg_addrvalid), 0);
    usb_rdn = 1'b1;
    tick(3);
    addr_phase(21'h000C80);
    usb_wrn = 1'b0;
    tick(1);
    reset_n = 1'b0;
    #1;
    chk("t6_rst_addr", 32'(bus.reg_address), 0);
    chk("t6_rst_valid", 32'(bus.reg_addrvalid), 0);
    chk("t6_rst_out", 32'({usb_dout, usb_isout, o_err}), 0);
    chk("t6_rst_wdata", 32'(bus.write_data), 0);
    tick(2);
    reset_n = 1'b1;
    tick(10);
    chk("t6_no_wr_after", wr_cnt, 13);
    chk("t6_no_rd_after", rd_cnt, 2);
    chk("t6_valid_after", 32'(bus.reg_addrvalid), 0);
    usb_wrn = 1'b1;
    usb_cen = 1'b1;
    tick(4);
    chk("wq_drained", 32'(wq.size()), 0);
    chk("rq_drained", 32'(rq.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
